// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM sequencer for a shared-ALU RISC-V datapath with a unified memory port
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [2:0] ALUMode,
    output logic [2:0] ImmFormat,
    output logic [1:0] ResultSrc,
    output logic       instr_retired,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, ILLEGAL
    } state_t;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    state_t r_state, w_next, w_dec;
    logic   w_f3_ok;
    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_next;
    end
    always_comb begin
        w_f3_ok = (opcode == OP_IMM)  ? (funct3 != 3'd2 && funct3 != 3'd3 && funct3 != 3'd6) :
                  (opcode == OP_REG)  ? (funct3 == 3'd0 || funct3 == 3'd6 || funct3 == 3'd7) :
                  (opcode == OP_BR)   ? (funct3[2:1] == 2'b00) :
                  (opcode == OP_JALR) ? (funct3 == 3'd0) : 1'b1;
        w_dec = !w_f3_ok ? ILLEGAL :
                (opcode == OP_LOAD || opcode == OP_STORE) ? MEMADR :
                (opcode == OP_REG)   ? EXECR :
                (opcode == OP_IMM)   ? EXECI :
                (opcode == OP_BR)    ? BRANCH :
                (opcode == OP_JAL)   ? JAL :
                (opcode == OP_JALR)  ? JALR1 :
                (opcode == OP_LUI)   ? LUI :
                (opcode == OP_AUIPC) ? AUIPC : ILLEGAL;
    end
    always_comb begin
        w_next        = r_state;
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUsrcA       = 2'd0;
        ALUsrcB       = 2'd0;
        ALUMode       = 3'd0;
        ImmFormat     = 3'd0;
        ResultSrc     = 2'd0;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUsrcA   = 2'd1;
                    ALUsrcB   = 2'd2;
                    ResultSrc = 2'd2;
                    w_next    = DECODE;
                end
            end
            DECODE: begin
                ALUsrcA   = 2'd2;
                ALUsrcB   = 2'd1;
                ImmFormat = (opcode == OP_JAL) ? 3'd3 : 3'd1;
                w_next    = w_dec;
            end
            MEMADR: begin
                ALUsrcB   = 2'd1;
                ImmFormat = (opcode == OP_STORE) ? 3'd4 : 3'd0;
                w_next    = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                w_next  = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc     = 2'd1;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                w_next        = FETCH;
            end
            MEMWRITE: begin
                mem_req       = 1'b1;
                AdrSrc        = 1'b1;
                MemWrite      = 1'b1;
                instr_retired = mem_ready;
                w_next        = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUMode = (funct3 == 3'd0) ? {2'b00, funct7[5]} :
                          (funct3 == 3'd6) ? 3'd3 : 3'd2;
                w_next  = ALUWB;
            end
            EXECI: begin
                ALUsrcB = 2'd1;
                ALUMode = (funct3 == 3'd1) ? 3'd5 :
                          (funct3 == 3'd4) ? 3'd4 :
                          (funct3 == 3'd5) ? 3'd6 :
                          (funct3 == 3'd7) ? 3'd2 : 3'd0;
                w_next  = ALUWB;
            end
            ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
                w_next        = FETCH;
            end
            BRANCH: begin
                ALUMode       = 3'd1;
                PCWrite       = funct3[0] ? !Zero : Zero;
                instr_retired = 1'b1;
                w_next        = FETCH;
            end
            JAL, JALR2: begin
                PCWrite = 1'b1;
                ALUsrcA = 2'd2;
                ALUsrcB = 2'd2;
                w_next  = ALUWB;
            end
            JALR1: begin
                ALUsrcB = 2'd1;
                w_next  = JALR2;
            end
            LUI: begin
                ALUsrcB   = 2'd1;
                ImmFormat = 3'd2;
                ALUMode   = 3'd7;
                w_next    = ALUWB;
            end
            AUIPC: begin
                ALUsrcA   = 2'd2;
                ALUsrcB   = 2'd1;
                ImmFormat = 3'd2;
                w_next    = ALUWB;
            end
            ILLEGAL: begin
                illegal       = 1'b1;
                instr_retired = 1'b1;
                w_next        = FETCH;
            end
            default: w_next = FETCH;
        endcase
        if (rst) begin
            mem_req       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            instr_retired = 1'b0;
            illegal       = 1'b0;
            w_next        = FETCH;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle stimulus with a scoreboard of expected control vectors
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, instr_retired, illegal;
    logic [1:0] ALUsrcA, ALUsrcB, ResultSrc;
    logic [2:0] ALUMode, ImmFormat;
    logic [19:0] w_out;
    typedef struct {
        string       tag;
        logic        r;
        logic        rdy;
        logic        z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [19:0] exp;
    } cyc_t;
    cyc_t stim[$];
    cyc_t sb[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    int n_chk = 0;
    int n_pass = 0;
    logic [19:0] e_frst, e_fwait, e_fdone, e_aluwb, e_jal;
    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUMode(ALUMode), .ImmFormat(ImmFormat),
        .ResultSrc(ResultSrc), .instr_retired(instr_retired), .illegal(illegal)
    );
    always #5 clk = ~clk;
    assign w_out = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ALUsrcA, ALUsrcB,
                    ALUMode, ImmFormat, ResultSrc, instr_retired, illegal};
    function automatic logic [19:0] mk(input logic req, adr, mw, irw, pcw, rw,
                                       input logic [1:0] a, b, input logic [2:0] m, imm,
                                       input logic [1:0] rs, input logic ret, ill);
        return {req, adr, mw, irw, pcw, rw, a, b, m, imm, rs, ret, ill};
    endfunction
    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h want %05h", tag, got, exp);
    endtask
    task automatic add(input string tag, input logic r, rdy, z, input logic [19:0] exp);
        cyc_t c;
        c.tag = tag; c.r = r; c.rdy = rdy; c.z = z;
        c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7; c.exp = exp;
        stim.push_back(c);
    endtask
    task automatic fetch_dec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [2:0] dimm, input int waits);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
        for (int i = 0; i < waits; i++) add({tag, "_fwait"}, 0, 0, 0, e_fwait);
        add({tag, "_fetch"}, 0, 1, 0, e_fdone);
        add({tag, "_decode"}, 0, 1, 0, mk(0,0,0,0,0,0, 2,1,0,dimm,0,0,0));
    endtask
    initial begin
        cyc_t c;
        e_frst  = mk(0,0,0,0,0,0, 1,2,0,0,2,0,0);
        e_fwait = mk(1,0,0,0,0,0, 0,0,0,0,0,0,0);
        e_fdone = mk(1,0,0,1,1,0, 1,2,0,0,2,0,0);
        e_aluwb = mk(0,0,0,0,0,1, 0,0,0,0,0,1,0);
        e_jal   = mk(0,0,0,0,1,0, 2,2,0,0,0,0,0);
        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 7'd0;
        add("reset0", 1, 1, 0, e_frst);
        add("reset1", 1, 1, 0, e_frst);
        fetch_dec("addi", 7'h13, 3'd0, 7'h00, 3'd1, 0);
        add("addi_exec", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,0,0,0,0,0));
        add("addi_wb", 0, 1, 0, e_aluwb);
        fetch_dec("sub", 7'h33, 3'd0, 7'h20, 3'd1, 0);
        add("sub_exec", 0, 1, 0, mk(0,0,0,0,0,0, 0,0,1,0,0,0,0));
        add("sub_wb", 0, 1, 0, e_aluwb);
        fetch_dec("and", 7'h33, 3'd7, 7'h00, 3'd1, 1);
        add("and_exec", 0, 1, 0, mk(0,0,0,0,0,0, 0,0,2,0,0,0,0));
        add("and_wb", 0, 1, 0, e_aluwb);
        fetch_dec("srli", 7'h13, 3'd5, 7'h00, 3'd1, 0);
        add("srli_exec", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,6,0,0,0,0));
        add("srli_wb", 0, 1, 0, e_aluwb);
        fetch_dec("lw", 7'h03, 3'd2, 7'h00, 3'd1, 0);
        add("lw_adr", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,0,0,0,0,0));
        add("lw_wait0", 0, 0, 0, mk(1,1,0,0,0,0, 0,0,0,0,0,0,0));
        add("lw_wait1", 0, 0, 0, mk(1,1,0,0,0,0, 0,0,0,0,0,0,0));
        add("lw_read", 0, 1, 0, mk(1,1,0,0,0,0, 0,0,0,0,0,0,0));
        add("lw_wb", 0, 1, 0, mk(0,0,0,0,0,1, 0,0,0,0,1,1,0));
        fetch_dec("sw", 7'h23, 3'd2, 7'h00, 3'd1, 0);
        add("sw_adr", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,0,4,0,0,0));
        add("sw_wait0", 0, 0, 0, mk(1,1,1,0,0,0, 0,0,0,0,0,0,0));
        add("sw_wait1", 0, 0, 0, mk(1,1,1,0,0,0, 0,0,0,0,0,0,0));
        add("sw_write", 0, 1, 0, mk(1,1,1,0,0,0, 0,0,0,0,0,1,0));
        fetch_dec("beq", 7'h63, 3'd0, 7'h00, 3'd1, 0);
        add("beq_br", 0, 1, 1, mk(0,0,0,0,1,0, 0,0,1,0,0,1,0));
        fetch_dec("bne", 7'h63, 3'd1, 7'h00, 3'd1, 0);
        add("bne_br", 0, 1, 1, mk(0,0,0,0,0,0, 0,0,1,0,0,1,0));
        fetch_dec("bnez", 7'h63, 3'd1, 7'h00, 3'd1, 0);
        add("bnez_br", 0, 1, 0, mk(0,0,0,0,1,0, 0,0,1,0,0,1,0));
        fetch_dec("jal", 7'h6F, 3'd0, 7'h00, 3'd3, 0);
        add("jal_jal", 0, 1, 0, e_jal);
        add("jal_wb", 0, 1, 0, e_aluwb);
        fetch_dec("jalr", 7'h67, 3'd0, 7'h00, 3'd1, 0);
        add("jalr_1", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,0,0,0,0,0));
        add("jalr_2", 0, 1, 0, e_jal);
        add("jalr_wb", 0, 1, 0, e_aluwb);
        fetch_dec("lui", 7'h37, 3'd0, 7'h00, 3'd1, 0);
        add("lui_ex", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,7,2,0,0,0));
        add("lui_wb", 0, 1, 0, e_aluwb);
        fetch_dec("auipc", 7'h17, 3'd0, 7'h00, 3'd1, 0);
        add("auipc_ex", 0, 1, 0, mk(0,0,0,0,0,0, 2,1,0,2,0,0,0));
        add("auipc_wb", 0, 1, 0, e_aluwb);
        fetch_dec("op7f", 7'h7F, 3'd0, 7'h00, 3'd1, 0);
        add("op7f_ill", 0, 1, 0, mk(0,0,0,0,0,0, 0,0,0,0,0,1,1));
        fetch_dec("imm_f3_2", 7'h13, 3'd2, 7'h00, 3'd1, 0);
        add("imm_f3_2_ill", 0, 1, 0, mk(0,0,0,0,0,0, 0,0,0,0,0,1,1));
        fetch_dec("lwrst", 7'h03, 3'd2, 7'h00, 3'd1, 0);
        add("lwrst_adr", 0, 1, 0, mk(0,0,0,0,0,0, 0,1,0,0,0,0,0));
        add("lwrst_rst", 1, 0, 0, mk(0,1,0,0,0,0, 0,0,0,0,0,0,0));
        add("post_rst_fetch", 0, 1, 0, e_fdone);
        while (stim.size() > 0) begin
            @(posedge clk);
            #1;
            c = stim.pop_front();
            rst = c.r; mem_ready = c.rdy; Zero = c.z;
            opcode = c.op; funct3 = c.f3; funct7 = c.f7;
            sb.push_back(c);
        end
        @(negedge clk);
        @(posedge clk);
        check("scoreboard_drain", 20'(sb.size()), 20'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        cyc_t s;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                s = sb.pop_front();
                check(s.tag, w_out, s.exp);
            end
        end
    end
endmodule
